// File: rtl/dft_bin_engine.sv
// Direct N-point DFT sequencer: drives external FP32 cores/ROMs and emits |X[k]|^2 per bin.
// Optional macro DFT_RAW_OUT_EN adds raw_re/raw_im outputs carrying the final accumulators.
module dft_bin_engine #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned ADD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] bin_first,
  input  logic [ADDR_W-1:0] bin_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_i_addr,
  output logic [ADDR_W-1:0] rom_tw_addr,
  input  logic [31:0]       rom_i_data,
  input  logic [31:0]       rom_cos_data,
  input  logic [31:0]       rom_sin_data,
  output logic [31:0]       mul1_a,
  output logic [31:0]       mul1_b,
  output logic [31:0]       mul2_a,
  output logic [31:0]       mul2_b,
  input  logic [31:0]       mul1_res,
  input  logic [31:0]       mul2_res,
  output logic [31:0]       add1_a,
  output logic [31:0]       add1_b,
  output logic [31:0]       add2_a,
  output logic [31:0]       add2_b,
  input  logic [31:0]       add1_res,
  input  logic [31:0]       add2_res,
  output logic [31:0]       mag_data,
  output logic [ADDR_W-1:0] mag_bin,
  output logic              mag_valid,
`ifdef DFT_RAW_OUT_EN
  output logic [31:0]       raw_re,
  output logic [31:0]       raw_im,
`endif
  input  logic              mag_ready
);

  localparam int unsigned MAX_LAT = (ROM_LAT > MUL_LAT) ?
                                    ((ROM_LAT > ADD_LAT) ? ROM_LAT : ADD_LAT) :
                                    ((MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 2);

  typedef enum logic [2:0] {IDLE, FETCH, MUL, ACC, MAG_MUL, MAG_ADD, OUT, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   k, k_last, n, tw;
  logic [31:0]         re_acc, im_acc;
  logic                cnt_clr, accept, next_bin, ld_addr, ld_mul, ld_add, cap_acc;
  logic                ld_mag_mul, ld_mag_add, cap_mag, hs;
  logic                clr_bin;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and per-cycle datapath strobes; ACC has one extra cycle after capture.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    accept     = 1'b0;
    next_bin   = 1'b0;
    ld_addr    = 1'b0;
    ld_mul     = 1'b0;
    ld_add     = 1'b0;
    cap_acc    = 1'b0;
    ld_mag_mul = 1'b0;
    ld_mag_add = 1'b0;
    cap_mag    = 1'b0;
    hs         = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        cnt_clr = 1'b1;
        if (bin_first > bin_last) state_next = DONE;
        else begin
          state_next = FETCH;
          ld_addr    = 1'b1;
        end
      end
      FETCH: if (cnt == CNT_W'(ROM_LAT - 1)) begin
        state_next = MUL;
        ld_mul     = 1'b1;
        cnt_clr    = 1'b1;
      end
      MUL: if (cnt == CNT_W'(MUL_LAT - 1)) begin
        state_next = ACC;
        ld_add     = 1'b1;
        cnt_clr    = 1'b1;
      end
      ACC: begin
        if (cnt == CNT_W'(ADD_LAT - 1)) cap_acc = 1'b1;
        if (cnt == CNT_W'(ADD_LAT)) begin
          cnt_clr = 1'b1;
          // n wrapped to 0 on the capture: last sample of this bin is done
          if (n == '0) begin
            state_next = MAG_MUL;
            ld_mag_mul = 1'b1;
          end else begin
            state_next = FETCH;
            ld_addr    = 1'b1;
          end
        end
      end
      MAG_MUL: if (cnt == CNT_W'(MUL_LAT - 1)) begin
        state_next = MAG_ADD;
        ld_mag_add = 1'b1;
        cnt_clr    = 1'b1;
      end
      MAG_ADD: if (cnt == CNT_W'(ADD_LAT - 1)) begin
        state_next = OUT;
        cap_mag    = 1'b1;
        cnt_clr    = 1'b1;
      end
      OUT: if (mag_ready) begin
        hs      = 1'b1;
        cnt_clr = 1'b1;
        if (k == k_last) state_next = DONE;
        else begin
          state_next = FETCH;
          next_bin   = 1'b1;
          ld_addr    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_clr    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_bin = accept | next_bin;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      k           <= '0;
      k_last      <= '0;
      n           <= '0;
      tw          <= '0;
      re_acc      <= '0;
      im_acc      <= '0;
      rom_i_addr  <= '0;
      rom_tw_addr <= '0;
      mul1_a      <= '0;
      mul1_b      <= '0;
      mul2_a      <= '0;
      mul2_b      <= '0;
      add1_a      <= '0;
      add1_b      <= '0;
      add2_a      <= '0;
      add2_b      <= '0;
      mag_data    <= '0;
      mag_bin     <= '0;
      mag_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef DFT_RAW_OUT_EN
      raw_re      <= '0;
      raw_im      <= '0;
`endif
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (accept) begin
        k      <= bin_first;
        k_last <= bin_last;
      end
      if (next_bin) k <= k + ADDR_W'(1);
      if (clr_bin) begin
        re_acc <= '0;
        im_acc <= '0;
        n      <= '0;
        tw     <= '0;
      end
      if (ld_addr) begin
        rom_i_addr  <= clr_bin ? '0 : n;
        rom_tw_addr <= clr_bin ? '0 : tw;
      end
      if (ld_mul) begin
        mul1_a <= rom_i_data;
        mul1_b <= rom_cos_data;
        mul2_a <= rom_i_data;
        mul2_b <= rom_sin_data;
      end
      // im accumulates -x*sin by flipping the product sign
      if (ld_add) begin
        add1_a <= re_acc;
        add1_b <= mul1_res;
        add2_a <= im_acc;
        add2_b <= {~mul2_res[31], mul2_res[30:0]};
      end
      if (cap_acc) begin
        re_acc <= add1_res;
        im_acc <= add2_res;
        n      <= n + ADDR_W'(1);
        tw     <= tw + k;
      end
      if (ld_mag_mul) begin
        mul1_a <= re_acc;
        mul1_b <= re_acc;
        mul2_a <= im_acc;
        mul2_b <= im_acc;
      end
      if (ld_mag_add) begin
        add1_a <= mul1_res;
        add1_b <= mul2_res;
      end
      if (cap_mag) begin
        mag_data  <= add1_res;
        mag_bin   <= k;
        mag_valid <= 1'b1;
`ifdef DFT_RAW_OUT_EN
        raw_re    <= re_acc;
        raw_im    <= im_acc;
`endif
      end
      if (hs) mag_valid <= 1'b0;
      busy <= (state_next != IDLE);
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_dft_bin_engine.sv
// Scoreboard bench for dft_bin_engine (N=8) with behavioural ROM and FP32 core models.
module tb_dft_bin_engine;
  localparam int ADDR_W  = 3;
  localparam int NS      = 8;
  localparam int ROM_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int ADD_LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] bin_first = '0, bin_last = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] rom_i_addr, rom_tw_addr;
  logic [31:0]       rom_i_data, rom_cos_data, rom_sin_data;
  logic [31:0]       mul1_a, mul1_b, mul2_a, mul2_b, mul1_res, mul2_res;
  logic [31:0]       add1_a, add1_b, add2_a, add2_b, add1_res, add2_res;
  logic [31:0]       mag_data;
  logic [ADDR_W-1:0] mag_bin;
  logic              mag_valid;
  logic              mag_ready = 1'b1;
`ifdef DFT_RAW_OUT_EN
  logic [31:0]       raw_re, raw_im;
`endif

  dft_bin_engine #(.ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_first(bin_first), .bin_last(bin_last),
    .busy(busy), .done(done), .rom_i_addr(rom_i_addr), .rom_tw_addr(rom_tw_addr),
    .rom_i_data(rom_i_data), .rom_cos_data(rom_cos_data), .rom_sin_data(rom_sin_data),
    .mul1_a(mul1_a), .mul1_b(mul1_b), .mul2_a(mul2_a), .mul2_b(mul2_b),
    .mul1_res(mul1_res), .mul2_res(mul2_res),
    .add1_a(add1_a), .add1_b(add1_b), .add2_a(add2_a), .add2_b(add2_b),
    .add1_res(add1_res), .add2_res(add2_res),
    .mag_data(mag_data), .mag_bin(mag_bin), .mag_valid(mag_valid),
`ifdef DFT_RAW_OUT_EN
    .raw_re(raw_re), .raw_im(raw_im),
`endif
    .mag_ready(mag_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] x_mem   [NS];
  logic [31:0] cos_tab [NS] = '{32'h3F800000, 32'h3F3504F3, 32'h00000000, 32'hBF3504F3,
                                 32'hBF800000, 32'hBF3504F3, 32'h00000000, 32'h3F3504F3};
  logic [31:0] sin_tab [NS] = '{32'h00000000, 32'h3F3504F3, 32'h3F800000, 32'h3F3504F3,
                                 32'h00000000, 32'hBF3504F3, 32'hBF800000, 32'hBF3504F3};

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e < 11'd897) return {d[63], 31'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // ROMs: combinational from the registered address (one edge of latency)
  assign rom_i_data   = x_mem[rom_i_addr];
  assign rom_cos_data = cos_tab[rom_tw_addr];
  assign rom_sin_data = sin_tab[rom_tw_addr];

  logic [31:0] m1_p [MUL_LAT-1];
  logic [31:0] m2_p [MUL_LAT-1];
  logic [31:0] a1_p [ADD_LAT-1];
  logic [31:0] a2_p [ADD_LAT-1];

  always @(posedge clk) begin
    m1_p[0] <= r2f(f2r(mul1_a) * f2r(mul1_b));
    m2_p[0] <= r2f(f2r(mul2_a) * f2r(mul2_b));
    a1_p[0] <= r2f(f2r(add1_a) + f2r(add1_b));
    a2_p[0] <= r2f(f2r(add2_a) + f2r(add2_b));
    for (int i = 1; i < MUL_LAT - 1; i++) begin
      m1_p[i] <= m1_p[i-1];
      m2_p[i] <= m2_p[i-1];
    end
    for (int i = 1; i < ADD_LAT - 1; i++) begin
      a1_p[i] <= a1_p[i-1];
      a2_p[i] <= a2_p[i-1];
    end
  end
  assign mul1_res = m1_p[MUL_LAT-2];
  assign mul2_res = m2_p[MUL_LAT-2];
  assign add1_res = a1_p[ADD_LAT-2];
  assign add2_res = a2_p[ADD_LAT-2];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] exp_bin_q [$];
  logic [31:0]       exp_data_q [$];
  logic [ADDR_W-1:0] eb;
  logic [31:0]       ed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_mag(input int k);
    real re, im;
    int  idx;
    re = 0.0;
    im = 0.0;
    for (int n = 0; n < NS; n++) begin
      idx = (k * n) % NS;
      re = re + f2r(x_mem[n]) * f2r(cos_tab[idx]);
      im = im - f2r(x_mem[n]) * f2r(sin_tab[idx]);
    end
    return r2f(re * re + im * im);
  endfunction

  task automatic set_x(input int sel);
    for (int n = 0; n < NS; n++) begin
      case (sel)
        0:       x_mem[n] = 32'h3F800000;
        1:       x_mem[n] = (n == 0) ? 32'h3F800000 : 32'h0;
        default: x_mem[n] = (n == 0) ? 32'h40400000 : (n == 2) ? 32'h40000000 :
                            (n == 4) ? 32'h3F800000 : 32'h0;
      endcase
    end
  endtask

  task automatic run(input int f, input int l);
    for (int k = f; k <= l; k++) begin
      exp_bin_q.push_back(ADDR_W'(k));
      exp_data_q.push_back(ref_mag(k));
    end
    @(posedge clk); #1;
    bin_first = ADDR_W'(f);
    bin_last  = ADDR_W'(l);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen;
    int base;
    seen = 0;
    base = done_cnt;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_pulses"}, 32'(done_cnt - base), 32'd1);
    check({tag, "_drain"}, 32'(exp_bin_q.size()), 32'd0);
  endtask

  always @(negedge clk) if (rst && done) done_cnt++;

  // Scoreboard: pop and compare on every valid/ready handshake
  always @(negedge clk) begin
    if (rst && mag_valid && mag_ready) begin
      if (exp_bin_q.size() == 0) check("sb_extra", 32'(mag_bin), 32'hFFFF_FFFF);
      else begin
        eb = exp_bin_q.pop_front();
        ed = exp_data_q.pop_front();
        check("mag_bin", 32'(mag_bin), 32'(eb));
        check("mag_data", mag_data, ed);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int found, busy_cycles, ns;
  int ia_seen [NS];
  int tw_seen [NS];
  int cy_seen [NS];
  logic [ADDR_W-1:0] last_ia;

  initial begin
    set_x(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(mag_valid), 32'd0);
    check("rst_iaddr", 32'(rom_i_addr), 32'd0);
    check("rst_twaddr", 32'(rom_tw_addr), 32'd0);
    check("rst_mag", mag_data, 32'd0);
    check("rst_mul1a", mul1_a, 32'd0);
    check("rst_add2b", add2_b, 32'd0);
    rst = 1'b1;

    // constant input, bin 0 only
    run(0, 0);
    wait_done("t1_done", 400);

    // impulse over all bins, then a mixed pattern with distinct magnitudes
    set_x(1);
    run(0, 7);
    wait_done("t2_done", 2000);
    set_x(2);
    run(0, 7);
    wait_done("t2b_done", 2000);

    // empty range
    busy_cycles = 0;
    run(5, 2);
    busy_cycles += int'(busy);
    @(posedge clk); #1;
    busy_cycles += int'(busy);
    check("t3_done_c2", 32'(done), 32'd1);
    @(posedge clk); #1;
    busy_cycles += int'(busy);
    check("t3_done_c3", 32'(done), 32'd0);
    check("t3_busy_le1", 32'(busy_cycles <= 1), 32'd1);
    check("t3_no_out", 32'(exp_bin_q.size()), 32'd0);

    // backpressure on bin 3
    run(2, 5);
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(posedge clk); #1;
      if (mag_valid && mag_bin == 3'd3) begin
        mag_ready = 1'b0;
        found = 1;
      end
    end
    check("t4_reach", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(mag_valid), 32'd1);
      check("t4_hold_bin", 32'(mag_bin), 32'd3);
      check("t4_hold_data", mag_data, 32'h41000000);
      check("t4_hold_twaddr", 32'(rom_tw_addr), 32'((3 * 7) % NS));
    end
    mag_ready = 1'b1;
    wait_done("t4_done", 1000);

    // reset in the middle of bin 2 accumulation
    run(0, 7);
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(posedge clk); #1;
      if (mag_valid && mag_ready && mag_bin == 3'd1) found = 1;
    end
    check("t5_reach", 32'(found), 32'd1);
    repeat (38) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_pending", 32'(exp_bin_q.size()), 32'd6);
    exp_bin_q.delete();
    exp_data_q.delete();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(mag_valid), 32'd0);
    check("t5_iaddr", 32'(rom_i_addr), 32'd0);
    check("t5_twaddr", 32'(rom_tw_addr), 32'd0);
    check("t5_add1a", add1_a, 32'd0);
    check("t5_mul2b", mul2_b, 32'd0);
    rst = 1'b1;
    set_x(0);
    run(0, 0);
    wait_done("t5_rerun", 400);

    // twiddle sequence and period for k=3, stray start while busy
    set_x(2);
    run(3, 3);
    ns = 1;
    ia_seen[0] = int'(rom_i_addr);
    tw_seen[0] = int'(rom_tw_addr);
    cy_seen[0] = 0;
    last_ia = rom_i_addr;
    for (int c = 1; c <= 85; c++) begin
      @(posedge clk); #1;
      if (c == 15) begin
        bin_first = '0;
        bin_last  = '0;
        start     = 1'b1;
      end
      if (c == 16) start = 1'b0;
      if (rom_i_addr != last_ia && ns < NS) begin
        ia_seen[ns] = int'(rom_i_addr);
        tw_seen[ns] = int'(rom_tw_addr);
        cy_seen[ns] = c;
        ns++;
      end
      last_ia = rom_i_addr;
    end
    check("t6_samples", 32'(ns), 32'(NS));
    for (int i = 0; i < ns; i++) begin
      check("t6_iaddr", 32'(ia_seen[i]), 32'(i));
      check("t6_twaddr", 32'(tw_seen[i]), 32'((3 * i) % NS));
      if (i > 0) check("t6_period", 32'(cy_seen[i] - cy_seen[i-1]), 32'd10);
    end
    wait_done("t6_done", 400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dft_bin_engine.md
Name: dft_bin_engine

Overview:
- Parametrised successor to the fixed single-point FFT top: sequences a direct DFT over N samples for a programmable range of bins.
- Drives two shared pipelined FP32 multipliers, two FP32 adders, an input-sample ROM and sin/cos twiddle ROMs, all external.
- Emits |X[k]|^2 per bin over a valid/ready stream.
- Sits between the ROM/IP-core layer and the downstream display/magnitude consumer.

Parameters:
- ADDR_W, 8: log2(N); sample ROM and twiddle ROM address width; N = 2^ADDR_W.
- ROM_LAT, 1: read latency of all ROMs, in cycles.
- MUL_LAT, 4: FP multiplier latency, in cycles.
- ADD_LAT, 4: FP adder latency, in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low. One clock; all state changes on the rising clk edge.
- start  in  1  one-cycle pulse; latches bin_first/bin_last; ignored while busy=1.
- bin_first  in  ADDR_W  first bin index.
- bin_last  in  ADDR_W  last bin index, inclusive.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last bin is accepted downstream.
- rom_i_addr  out  ADDR_W  sample ROM address n.
- rom_tw_addr  out  ADDR_W  twiddle ROM address (k*n) mod N.
- rom_i_data  in  32  x[n], FP32.
- rom_cos_data, rom_sin_data  in  32  cos/sin(2*pi*addr/N), FP32.
- mul1_a, mul1_b, mul2_a, mul2_b  out  32  multiplier operands (registered).
- mul1_res, mul2_res  in  32  multiplier results.
- add1_a, add1_b, add2_a, add2_b  out  32  adder operands (registered).
- add1_res, add2_res  in  32  adder results.
- mag_data  out  32  FP32 re^2+im^2.
- mag_bin  out  ADDR_W  bin index k of mag_data.
- mag_valid  out  1  output valid.
- mag_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=0 at an edge), regardless of current state:
  - FSM -> IDLE.
  - busy, done, mag_valid = 0.
  - All addresses, operands, mag_data, mag_bin and both accumulators = 0.
  - An operation in flight is abandoned; results returning from the cores afterwards are ignored.
- FSM states: IDLE, FETCH, MUL, ACC, MAG_MUL, MAG_ADD, OUT, DONE.
- IDLE, start=1:
  - Latch the bin range; k = bin_first.
  - Clear re_acc/im_acc to +0.0; n = 0; tw = 0; go to FETCH.
  - If bin_first > bin_last: go straight to DONE and emit no outputs.
- FETCH: drive rom_i_addr = n and rom_tw_addr = tw; wait ROM_LAT cycles.
- MUL:
  - mul1 = x*cos, mul2 = x*sin.
  - Wait MUL_LAT cycles.
- ACC:
  - add1 = re_acc + mul1_res.
  - add2 = im_acc + (mul2_res with bit 31 inverted), i.e. im -= x*sin.
  - Wait ADD_LAT cycles, then capture add1_res -> re_acc and add2_res -> im_acc.
- Sample step and timing:
  - Each sample takes exactly ROM_LAT+MUL_LAT+ADD_LAT+1 cycles from entering FETCH to re-entering FETCH; default is 10.
  - One sample in flight at a time, so there is no accumulator hazard.
- After each capture:
  - n increments; tw increments by k, modulo 2^ADDR_W with natural wrap.
  - When n was N-1, go to MAG_MUL.
- MAG_MUL: mul1 = re*re, mul2 = im*im; wait MUL_LAT.
- MAG_ADD: add1 = mul1_res + mul2_res; wait ADD_LAT; capture into mag_data; mag_bin = k; go to OUT.
- OUT:
  - mag_valid = 1; mag_data and mag_bin stay stable until mag_ready=1 at an edge.
  - On that handshake:
    - If k == bin_last, go to DONE.
    - Otherwise k++, clear accumulators, n = 0, tw = 0, go to FETCH.
  - k == 2^ADDR_W-1 as bin_last is legal; no wrap past it.
- DONE: done = 1 for one cycle; busy = 0 in that same cycle; then IDLE.
- Wait counters are sized for max(ROM_LAT, MUL_LAT, ADD_LAT); a latency of 0 is not supported (minimum 1).
- Operand registers hold their last value outside the states that use them.

Optional Feature:
- Macro: DFT_RAW_OUT_EN.
- Defined:
  - Two extra outputs, raw_re and raw_im (32 bits each), carry the final re_acc/im_acc of the bin.
  - They are valid with the same mag_valid/mag_ready handshake and are 0 after reset.
- Undefined: the ports are absent and the accumulators are internal only.
- Timing is identical either way.

Test Plan:
1. Defaults with ADDR_W=3; x[n] = 1.0 (0x3F800000) for all n; range 0..0 -> one output: mag_bin=0, mag_data=64.0 (0x42800000); done pulses once.
2. ADDR_W=3; impulse x[0]=1.0, others 0.0; range 0..7 -> eight outputs, bins 0..7 in order, each mag_data=0x3F800000.
3. Range 5..2 -> no mag_valid; done pulses once, 2 cycles after start; busy high for at most 1 cycle.
4. Hold mag_ready=0 for 20 cycles on bin 3 -> mag_valid, mag_data and mag_bin stay constant; no further ROM address change; bin 4 proceeds after release.
5. Assert rst=0 for one cycle mid-ACC of bin 2 -> next cycle busy=0, mag_valid=0, all addresses 0; a new start for range 0..0 then gives the same result as test 1.
6. start pulsed while busy -> ignored; check rom_tw_addr sequence for k=3, N=8: 0,3,6,1,4,7,2,5; per-sample period 10 cycles.
